// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a word on valid/busy and steps the TX mux
// through start, LSB-first data, optional parity and stop, one bit per CLK.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  PAR_BIT,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [1:0]            mux_sel_q, mux_sel_d;
    logic                  ser_data_q, ser_data_d;
    logic                  busy_q, busy_d;

    // Next-state and datapath latching
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Data_Valid) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    // Parity type only matters here, so it is folded into PAR_BIT at accept
                    par_bit_d = PAR_TYP ^ (^P_DATA);
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_comb begin
        mux_sel_d  = MUX_STOP;
        busy_d     = 1'b1;
        ser_data_d = 1'b0;
        case (state_d)
            S_IDLE:   busy_d    = 1'b0;
            S_START:  mux_sel_d = MUX_START;
            S_DATA: begin
                mux_sel_d  = MUX_DATA;
                ser_data_d = data_d[cnt_d];
            end
            S_PARITY: mux_sel_d = MUX_PAR;
            S_STOP:   mux_sel_d = MUX_STOP;
            default:  busy_d    = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            mux_sel_q  <= MUX_STOP;
            ser_data_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            mux_sel_q  <= mux_sel_d;
            ser_data_q <= ser_data_d;
            busy_q     <= busy_d;
        end
    end

    assign mux_sel  = mux_sel_q;
    assign ser_data = ser_data_q;
    assign PAR_BIT  = par_bit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frames are checked cycle by cycle against
// hand-computed bit sequences, parity values and busy lengths.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          PAR_BIT;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
        .ser_data(ser_data), .PAR_BIT(PAR_BIT), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Line level as the downstream mux would produce it
    function automatic logic tx_out();
        case (mux_sel)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return ser_data;
            default: return PAR_BIT;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge of a frame's START cycle; walks through the
    // frame and the following idle cycle. inj>=0 fires a stray request at that cycle.
    task automatic check_frame(input string name, input logic [DW-1:0] d, input logic pe,
                               input logic exp_par, input int inj);
        int len;
        int busy_n;
        busy_n = 0;
        len    = 2 + DW + int'(pe);
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge CLK);
            busy_n += int'(busy);
            if (c == 0) begin
                chk({name, " start mux"}, 32'(mux_sel), 32'd0);
                chk({name, " start tx"}, 32'(tx_out()), 32'd0);
            end else if (c <= DW) begin
                chk($sformatf("%s data%0d mux", name, c - 1), 32'(mux_sel), 32'd2);
                chk($sformatf("%s data%0d tx", name, c - 1), 32'(tx_out()), 32'(d[c-1]));
            end else if (pe && c == DW + 1) begin
                chk({name, " par mux"}, 32'(mux_sel), 32'd3);
                chk({name, " par bit"}, 32'(PAR_BIT), 32'(exp_par));
            end else begin
                chk({name, " stop mux"}, 32'(mux_sel), 32'd1);
                chk({name, " stop tx"}, 32'(tx_out()), 32'd1);
            end
            if (c == inj) begin
                P_DATA     = 8'hF0;
                PAR_EN     = 1'b1;
                Data_Valid = 1'b1;
            end else if (inj >= 0 && c == inj + 1) begin
                Data_Valid = 1'b0;
            end
        end
        chk({name, " busy len"}, 32'(busy_n), 32'(len));
        @(negedge CLK);
        chk({name, " idle busy"}, 32'(busy), 32'd0);
        chk({name, " idle mux"}, 32'(mux_sel), 32'd1);
    endtask

    // Present a request for one accepting edge; returns at the START falling edge
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    initial begin
        // 1. reset and idle
        #2 RST = 1'b1;
        #1;
        chk("rst mux", 32'(mux_sel), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ser", 32'(ser_data), 32'd0);
        chk("rst par", 32'(PAR_BIT), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("idle%0d mux", i), 32'(mux_sel), 32'd1);
            chk($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
            chk($sformatf("idle%0d tx", i), 32'(tx_out()), 32'd1);
        end

        // 2. 0xB3 no parity: line 0,1,1,0,0,1,1,0,1,1
        send(8'hB3, 1'b0, 1'b0);
        check_frame("b3np", 8'hB3, 1'b0, 1'b0, -1);

        // 3. 0xB3 has five ones: even parity bit 1, odd parity bit 0
        @(negedge CLK);
        send(8'hB3, 1'b1, 1'b0);
        check_frame("b3even", 8'hB3, 1'b1, 1'b1, -1);
        @(negedge CLK);
        send(8'hB3, 1'b1, 1'b1);
        check_frame("b3odd", 8'hB3, 1'b1, 1'b0, -1);

        // 4. request while busy is dropped and does not touch the frame
        @(negedge CLK);
        send(8'h0F, 1'b0, 1'b0);
        check_frame("inj", 8'h0F, 1'b0, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("inj noframe%0d", i), 32'(busy), 32'd0);
        end

        // 5. Data_Valid held: one idle cycle between frames, period 11
        @(negedge CLK);
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        t0 = cyc;
        check_frame("b2b0", 8'h55, 1'b0, 1'b0, -1);
        @(negedge CLK);
        chk("b2b period", 32'(cyc - t0), 32'd11);
        check_frame("b2b1", 8'h55, 1'b0, 1'b0, -1);
        Data_Valid = 1'b0;

        // 6. reset during the 4th data bit
        @(negedge CLK);
        send(8'hA6, 1'b1, 1'b1);
        repeat (4) @(negedge CLK);
        chk("pre-rst mux", 32'(mux_sel), 32'd2);
        RST = 1'b1;
        #1;
        chk("midrst mux", 32'(mux_sel), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("postrst%0d busy", i), 32'(busy), 32'd0);
            chk($sformatf("postrst%0d mux", i), 32'(mux_sel), 32'd1);
        end
        // 0xA6 has four ones: odd parity bit 1
        send(8'hA6, 1'b1, 1'b1);
        check_frame("a6odd", 8'hA6, 1'b1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=done", cyc);
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a parallel word through a valid/busy handshake and latches the word and its frame configuration.
- Steps the TX output mux through start, data (LSB first), optional parity, and stop bit, one bit per CLK cycle.
- Sits between the TX data source (FIFO/system control) and the TX output mux. CLK is the already-divided TX bit clock.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal range 5..9)
CNT_WIDTH, $clog2(DATA_WIDTH), width of the internal bit counter

Ports:
CLK  input  1  TX bit clock; all state changes on the rising edge
RST  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  request to send P_DATA; sampled only while busy=0
PAR_EN  input  1  1 = parity bit inserted; latched at accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; latched at accept
mux_sel  output  2  TX mux select: 00 start, 01 stop/idle, 10 serial data, 11 parity
ser_data  output  1  current data bit for the mux
PAR_BIT  output  1  parity bit of the latched word
busy  output  1  frame in progress; new requests are ignored while high

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - State = IDLE, counter = 0.
  - mux_sel = 01 (line held at stop/idle level 1).
  - busy = 0, ser_data = 0, PAR_BIT = 0.
  - Data and configuration registers are cleared.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - mux_sel = 01, busy = 0.
  - On an edge with Data_Valid=1: latch P_DATA, PAR_EN, PAR_TYP; compute PAR_BIT; go to START.
- START (1 cycle): mux_sel = 00, busy = 1. Next state is DATA with counter = 0.
- DATA (DATA_WIDTH cycles):
  - mux_sel = 10.
  - ser_data = latched_data[counter], LSB first.
  - Counter increments each cycle.
  - When counter = DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else go to STOP.
- PARITY (1 cycle): mux_sel = 11. PAR_BIT is held stable from accept until the next accept.
- STOP (1 cycle): mux_sel = 01, busy = 1. Next state is IDLE, where busy drops to 0.
- Parity arithmetic: even = XOR-reduce(latched_data); odd = inverted XOR-reduce(latched_data).
- Latency and frame timing:
  - The first START cycle is the cycle after the accepting edge.
  - busy is high for exactly 2 + DATA_WIDTH + PAR_EN cycles.
  - At least 1 IDLE cycle separates frames. Back-to-back Data_Valid gives a frame period of 3 + DATA_WIDTH + PAR_EN cycles.
- Input changes while busy=1:
  - Data_Valid, P_DATA, PAR_EN and PAR_TYP changes have no effect on the frame in flight.
  - A Data_Valid pulse seen only while busy=1 is dropped. It is not queued.
- Counter wrap: the counter never exceeds DATA_WIDTH-1. It resets to 0 on entry to START.
- Illegal state encoding: recovers to IDLE on the next edge with mux_sel = 01 and busy = 0.

Test Plan:
1. Reset, then idle 5 cycles:
   - mux_sel = 01, busy = 0, TX_OUT = 1 every cycle.
2. DATA_WIDTH=8, P_DATA=0xB3, PAR_EN=0, 1-cycle Data_Valid:
   - TX_OUT = 0, 1,1,0,0,1,1,0,1, then 1.
   - busy high for exactly 10 cycles.
3. P_DATA=0xB3, PAR_EN=1:
   - PAR_TYP=0: parity cycle has mux_sel = 11, PAR_BIT = 1; busy high 11 cycles.
   - Repeat with PAR_TYP=1: PAR_BIT = 0.
4. Accept 0x0F. In cycle 3 of the frame, drive P_DATA=0xF0, PAR_EN=1, Data_Valid=1 for one cycle:
   - Frame still serialises 0x0F with no parity.
   - No second frame starts.
5. Data_Valid held high with P_DATA=0x55, PAR_EN=0:
   - Consecutive frames separated by exactly 1 idle cycle.
   - Period = 11 cycles.
6. Assert RST during the 4th data bit:
   - Same cycle: mux_sel = 01, busy = 0.
   - After release with Data_Valid=0: stays IDLE.
   - Next Data_Valid produces a complete, correct frame.
